// File: rtl/gelato_decode_unit_pkg.sv
// Shared decode types and helpers for the gelato decode stage and fetch-side predecode.
// Optional counters in the decode unit are enabled with GELATO_DECODE_PERF_EN.
package gelato_decode_unit_pkg;

    localparam int ADDR_WIDTH     = 32;
    localparam int DATA_WIDTH     = 32;
    localparam int WARP_NUM_WIDTH = 5;

    typedef logic [ADDR_WIDTH-1:0]     addr_t;
    typedef logic [DATA_WIDTH-1:0]     data_t;
    typedef logic [WARP_NUM_WIDTH-1:0] warp_num_t;

    typedef enum logic [6:0] {
        OPC_LOAD     = 7'b0000011,
        OPC_LOAD_FP  = 7'b0000111,
        OPC_MISC_MEM = 7'b0001111,
        OPC_OP_IMM   = 7'b0010011,
        OPC_AUIPC    = 7'b0010111,
        OPC_STORE    = 7'b0100011,
        OPC_STORE_FP = 7'b0100111,
        OPC_OP       = 7'b0110011,
        OPC_LUI      = 7'b0110111,
        OPC_MADD     = 7'b1000011,
        OPC_MSUB     = 7'b1000111,
        OPC_NMSUB    = 7'b1001011,
        OPC_NMADD    = 7'b1001111,
        OPC_OP_FP    = 7'b1010011,
        OPC_BRANCH   = 7'b1100011,
        OPC_JALR     = 7'b1100111,
        OPC_JAL      = 7'b1101111,
        OPC_SYSTEM   = 7'b1110011
    } opcode_e;

    // Field slices are taken verbatim from the raw word, whatever the format.
    typedef struct packed {
        logic [6:0] opcode;
        logic [4:0] rd;
        logic [2:0] funct3;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rs3;
        logic [6:0] funct7;
        data_t      imm;
    } inst_t;

    function automatic logic is_legal(input logic [31:0] raw);
        logic legal_v;
        legal_v = 1'b0;
        if (raw[1:0] == 2'b11) begin
            case (raw[6:0])
                OPC_LOAD, OPC_LOAD_FP, OPC_MISC_MEM, OPC_OP_IMM, OPC_AUIPC, OPC_STORE,
                OPC_STORE_FP, OPC_OP, OPC_LUI, OPC_MADD, OPC_MSUB, OPC_NMSUB, OPC_NMADD,
                OPC_OP_FP, OPC_BRANCH, OPC_JALR, OPC_JAL, OPC_SYSTEM: legal_v = 1'b1;
                default: legal_v = 1'b0;
            endcase
        end else begin
            legal_v = 1'b0;
        end
        return legal_v;
    endfunction

    // Illegal encodings and R/R4 formats yield a zero immediate.
    function automatic data_t decode_imm(input logic [31:0] raw);
        data_t imm_v;
        imm_v = {DATA_WIDTH{1'b0}};
        if (raw[1:0] == 2'b11) begin
            case (raw[6:0])
                OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_LOAD_FP, OPC_SYSTEM, OPC_MISC_MEM:
                    imm_v = data_t'($signed(raw[31:20]));
                OPC_STORE, OPC_STORE_FP:
                    imm_v = data_t'($signed({raw[31:25], raw[11:7]}));
                OPC_BRANCH:
                    imm_v = data_t'($signed({raw[31], raw[7], raw[30:25], raw[11:8], 1'b0}));
                OPC_LUI, OPC_AUIPC:
                    imm_v = data_t'($signed({raw[31:12], 12'h000}));
                OPC_JAL:
                    imm_v = data_t'($signed({raw[31], raw[19:12], raw[20], raw[30:21], 1'b0}));
                default:
                    imm_v = {DATA_WIDTH{1'b0}};
            endcase
        end else begin
            imm_v = {DATA_WIDTH{1'b0}};
        end
        return imm_v;
    endfunction

endpackage

// File: rtl/gelato_decode_unit_if.sv
// Fetch-to-decode-to-issue bundle: input beat, per-warp flush and decoded output beat.
interface gelato_decode_if;
    import gelato_decode_unit_pkg::*;

    logic      in_valid;
    logic      in_ready;
    warp_num_t in_warp;
    addr_t     in_pc;
    logic [31:0] in_raw;
    logic      flush_valid;
    warp_num_t flush_warp;
    logic      out_valid;
    logic      out_ready;
    warp_num_t out_warp;
    addr_t     out_pc;
    inst_t     out_inst;
    logic      out_illegal;

    modport slave (
        input  in_valid, in_warp, in_pc, in_raw, flush_valid, flush_warp, out_ready,
        output in_ready, out_valid, out_warp, out_pc, out_inst, out_illegal
    );

    modport master (
        output in_valid, in_warp, in_pc, in_raw, flush_valid, flush_warp, out_ready,
        input  in_ready, out_valid, out_warp, out_pc, out_inst, out_illegal
    );
endinterface

// File: rtl/gelato_decode_unit_skid_buffer.sv
// Generic 2-entry FIFO-ordered valid/ready skid with per-entry kill; the kill key is
// the top KEY_W bits of the payload so the owner can match entries without seeing them.
module gelato_skid_buffer #(
    parameter int WIDTH = 8,
    parameter int KEY_W = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_kill_in,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    input  logic             i_kill_out,
    output logic [KEY_W-1:0] o_skid_key,
    input  logic             i_kill_skid
);

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_skid_valid;
    logic [WIDTH-1:0] r_skid_data;
    logic             r_in_ready;

    logic             w_out_fire;
    logic             w_out_keep;
    logic             w_skid_keep;
    logic             w_in_take;
    logic             w_out_valid_nx;
    logic [WIDTH-1:0] w_out_data_nx;
    logic             w_skid_valid_nx;
    logic [WIDTH-1:0] w_skid_data_nx;

    // Next occupancy: survivors are compacted oldest-first into output then skid.
    always_comb begin
        w_out_fire      = r_out_valid && i_ready;
        w_out_keep      = r_out_valid && !w_out_fire && !i_kill_out;
        w_skid_keep     = r_skid_valid && !i_kill_skid;
        w_in_take       = i_valid && r_in_ready && !i_kill_in;
        w_out_valid_nx  = 1'b0;
        w_out_data_nx   = r_out_data;
        w_skid_valid_nx = 1'b0;
        w_skid_data_nx  = r_skid_data;
        if (w_out_keep) begin
            w_out_valid_nx = 1'b1;
            if (w_skid_keep) begin
                w_skid_valid_nx = 1'b1;
            end else if (w_in_take) begin
                w_skid_valid_nx = 1'b1;
                w_skid_data_nx  = i_data;
            end else begin
                w_skid_valid_nx = 1'b0;
            end
        end else if (w_skid_keep) begin
            w_out_valid_nx = 1'b1;
            w_out_data_nx  = r_skid_data;
            if (w_in_take) begin
                w_skid_valid_nx = 1'b1;
                w_skid_data_nx  = i_data;
            end else begin
                w_skid_valid_nx = 1'b0;
            end
        end else if (w_in_take) begin
            w_out_valid_nx = 1'b1;
            w_out_data_nx  = i_data;
        end else begin
            w_out_valid_nx = 1'b0;
        end
    end

    // Storage registers; in_ready is precomputed so it never depends on i_ready.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= {WIDTH{1'b0}};
            r_skid_valid <= 1'b0;
            r_skid_data  <= {WIDTH{1'b0}};
            r_in_ready   <= 1'b1;
        end else begin
            r_out_valid  <= w_out_valid_nx;
            r_out_data   <= w_out_data_nx;
            r_skid_valid <= w_skid_valid_nx;
            r_skid_data  <= w_skid_data_nx;
            r_in_ready   <= !w_skid_valid_nx;
        end
    end

    assign o_ready    = r_in_ready;
    assign o_valid    = r_out_valid;
    assign o_data     = r_out_data;
    assign o_skid_key = r_skid_data[WIDTH-1 -: KEY_W];

endmodule

// File: rtl/gelato_decode_unit.sv
// RV32 decode stage: decodes the incoming word and carries it through a 2-entry skid
// with per-warp flush. Define GELATO_DECODE_PERF_EN to add the perf_* counters.
module gelato_decode_unit
    import gelato_decode_unit_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    gelato_decode_if.slave   dec
`ifdef GELATO_DECODE_PERF_EN
    ,
    output logic [31:0]      perf_decoded,
    output logic [31:0]      perf_stall,
    output logic [31:0]      perf_flushed
`endif
);

    // Warp sits in the MSBs so the skid buffer can expose it as the kill key.
    typedef struct packed {
        warp_num_t warp;
        addr_t     pc;
        inst_t     inst;
        logic      illegal;
    } entry_t;

    localparam int PAYLOAD_W = $bits(entry_t);

    inst_t     w_inst;
    logic      w_illegal;
    entry_t    w_in_entry;
    entry_t    w_out_entry;
    warp_num_t w_skid_key;
    logic      w_in_ready;
    logic      w_out_valid;
    logic      w_flush_in;
    logic      w_kill_out;
    logic      w_kill_skid;

    // Field extraction and immediate generation on the raw word.
    always_comb begin
        w_inst.opcode = dec.in_raw[6:0];
        w_inst.rd     = dec.in_raw[11:7];
        w_inst.funct3 = dec.in_raw[14:12];
        w_inst.rs1    = dec.in_raw[19:15];
        w_inst.rs2    = dec.in_raw[24:20];
        w_inst.rs3    = dec.in_raw[31:27];
        w_inst.funct7 = dec.in_raw[31:25];
        w_inst.imm    = decode_imm(dec.in_raw);
        w_illegal     = !is_legal(dec.in_raw);
        w_in_entry    = '{warp: dec.in_warp, pc: dec.in_pc, inst: w_inst, illegal: w_illegal};
    end

    // Flush matching for the input beat and both buffered slots.
    always_comb begin
        w_flush_in  = dec.flush_valid && (dec.in_warp == dec.flush_warp);
        w_kill_out  = dec.flush_valid && (w_out_entry.warp == dec.flush_warp);
        w_kill_skid = dec.flush_valid && (w_skid_key == dec.flush_warp);
    end

    gelato_skid_buffer #(
        .WIDTH (PAYLOAD_W),
        .KEY_W (WARP_NUM_WIDTH)
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_valid     (dec.in_valid),
        .o_ready     (w_in_ready),
        .i_data      (w_in_entry),
        .i_kill_in   (w_flush_in),
        .o_valid     (w_out_valid),
        .i_ready     (dec.out_ready),
        .o_data      (w_out_entry),
        .i_kill_out  (w_kill_out),
        .o_skid_key  (w_skid_key),
        .i_kill_skid (w_kill_skid)
    );

    assign dec.in_ready    = w_in_ready;
    assign dec.out_valid   = w_out_valid;
    assign dec.out_warp    = w_out_entry.warp;
    assign dec.out_pc      = w_out_entry.pc;
    assign dec.out_inst    = w_out_entry.inst;
    assign dec.out_illegal = w_out_entry.illegal;

`ifdef GELATO_DECODE_PERF_EN
    logic        w_out_fire;
    logic [1:0]  w_kill_cnt;
    logic [31:0] r_perf_decoded;
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_flushed;

    // A firing output entry counts as delivered, never as flushed; skid is full iff !in_ready.
    always_comb begin
        w_out_fire = w_out_valid && dec.out_ready;
        w_kill_cnt = {1'b0, w_kill_out && w_out_valid && !dec.out_ready}
                   + {1'b0, w_kill_skid && !w_in_ready}
                   + {1'b0, w_flush_in && dec.in_valid && w_in_ready};
    end

    // Wrapping event counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_perf_decoded <= 32'd0;
            r_perf_stall   <= 32'd0;
            r_perf_flushed <= 32'd0;
        end else begin
            r_perf_decoded <= r_perf_decoded + {31'd0, w_out_fire};
            r_perf_stall   <= r_perf_stall + {31'd0, w_out_valid && !dec.out_ready};
            r_perf_flushed <= r_perf_flushed + {30'd0, w_kill_cnt};
        end
    end

    assign perf_decoded = r_perf_decoded;
    assign perf_stall   = r_perf_stall;
    assign perf_flushed = r_perf_flushed;
`endif

endmodule
